// File: rtl/counter.sv
// Parameterised up-counter: counts 0..MAX_COUNT with enable, synchronous clear,
// and a one-cycle registered overflow pulse on each terminal-count wrap.
module counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] count_o,
    output logic             overflow_o
);

    // MAX_COUNT is an int, so any WIDTH of 31 or more can hold it.
    localparam bit MAX_FITS = (WIDTH >= 31) ? 1'b1
                            : (MAX_COUNT <= ((1 << WIDTH) - 1));
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        count_d    = count_q;
        overflow_d = 1'b0;
        if (clear_i) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (en_i) begin
            // >= rather than == so an out-of-range count still wraps cleanly.
            if (count_q >= MAX_W) begin
                count_d    = '0;
                overflow_d = 1'b1;
            end else begin
                count_d    = count_q + WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count_o    = count_q;
    assign overflow_o = overflow_q;

    // ------------------------------------------------------------------
    // Parameter checks and assertions
    // ------------------------------------------------------------------
    if (WIDTH < 1) begin : g_bad_width
        $error("counter: WIDTH must be >= 1");
    end
    if (MAX_COUNT < 1) begin : g_bad_max_low
        $error("counter: MAX_COUNT must be >= 1");
    end
    if (!MAX_FITS) begin : g_bad_max_high
        $error("counter: MAX_COUNT must fit in WIDTH bits");
    end

    a_count_in_range : assert property (
        @(posedge clk_i) disable iff (rst_i) count_q <= MAX_W
    );

    a_overflow_at_zero : assert property (
        @(posedge clk_i) disable iff (rst_i) overflow_q |-> (count_q == '0)
    );

    a_overflow_single : assert property (
        @(posedge clk_i) disable iff (rst_i) overflow_q |=> !overflow_q
    );

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter (WIDTH=8, MAX_COUNT=10): a reference model
// pushes expected {overflow, count} per driven edge; results are popped after the edge.
module tb_counter;

    localparam int WIDTH     = 8;
    localparam int MAX_COUNT = 10;
    localparam int EW        = WIDTH + 1;

    logic             clk_i;
    logic             rst_i;
    logic             en_i;
    logic             clear_i;
    logic [WIDTH-1:0] count_o;
    logic             overflow_o;

    int checks;
    int errors;
    int pulse_cnt;

    logic [EW-1:0]    exp_q[$];
    logic [WIDTH-1:0] model_count;
    logic             model_ovf;

    counter #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .clear_i    (clear_i),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    // clock / reset block
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        model_count = '0;
        model_ovf   = 1'b0;
    endtask

    // Reference behaviour for one rising edge.
    task automatic model_edge(input logic en, input logic clr);
        if (clr) begin
            model_count = '0;
            model_ovf   = 1'b0;
        end else if (en) begin
            if (model_count == WIDTH'(MAX_COUNT)) begin
                model_count = '0;
                model_ovf   = 1'b1;
            end else begin
                model_count = model_count + 1'b1;
                model_ovf   = 1'b0;
            end
        end else begin
            model_ovf = 1'b0;
        end
    endtask

    // Driver: called away from the edge; drives inputs, predicts, then compares.
    task automatic step(input string tag, input logic en, input logic clr);
        logic [EW-1:0] exp;
        en_i    = en;
        clear_i = clr;
        model_edge(en, clr);
        exp_q.push_back({model_ovf, model_count});
        @(posedge clk_i);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_count"}, 32'(count_o), 32'(exp[WIDTH-1:0]));
            check({tag, "_ovf"}, 32'(overflow_o), 32'(exp[WIDTH]));
            if (overflow_o) pulse_cnt++;
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        pulse_cnt = 0;
        rst_i     = 1'b1;
        en_i      = 1'b0;
        clear_i   = 1'b0;
        model_reset();

        // Reset acts before any clock edge and holds for 5 cycles.
        #2;
        check("rst_async_count", 32'(count_o), 32'd0);
        check("rst_async_ovf", 32'(overflow_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            en_i = 1'b1;
            @(posedge clk_i);
            #1;
            check("rst_hold_count", 32'(count_o), 32'd0);
            check("rst_hold_ovf", 32'(overflow_o), 32'd0);
        end
        en_i  = 1'b0;
        rst_i = 1'b0;

        for (int i = 0; i < 10; i++) step("idle", 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)  step("count5", 1'b1, 1'b0);
        check("count5_value", 32'(count_o), 32'd5);

        // 6,7,8,9,10,0(ovf) then 1.
        for (int i = 0; i < 6; i++) step("wrap", 1'b1, 1'b0);
        check("wrap_zero", 32'(count_o), 32'd0);
        check("wrap_pulse", 32'(overflow_o), 32'd1);
        step("post_wrap", 1'b1, 1'b0);
        check("post_wrap_ovf_low", 32'(overflow_o), 32'd0);

        step("clear", 1'b1, 1'b1);
        step("after_clear", 1'b1, 1'b0);

        // Clear wins over a terminal-count wrap.
        while (model_count != WIDTH'(MAX_COUNT)) step("to_max", 1'b1, 1'b0);
        step("clear_at_max", 1'b1, 1'b1);
        check("clear_at_max_no_pulse", 32'(overflow_o), 32'd0);

        // Mid-count asynchronous reset.
        while (model_count != 8'd7) step("to_seven", 1'b1, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst_count", 32'(count_o), 32'd0);
        check("midrst_ovf", 32'(overflow_o), 32'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        check("midrst_hold", 32'(count_o), 32'd0);
        rst_i = 1'b0;
        step("rst_release", 1'b1, 1'b0);
        check("rst_release_one", 32'(count_o), 32'd1);

        // Continuous enable from 0: one pulse every MAX_COUNT+1 edges.
        step("cont_clear", 1'b0, 1'b1);
        pulse_cnt = 0;
        for (int i = 0; i < 3 * (MAX_COUNT + 1); i++) step("cont", 1'b1, 1'b0);
        check("cont_pulses", 32'(pulse_cnt), 32'd3);

        // Random enable / clear mix.
        for (int i = 0; i < 300; i++) begin
            step("rand", logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 15) == 0));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter.md
Name: counter

Overview:
- Parameterised up-counter with enable, synchronous clear and terminal-count wrap.
- Counts 0..MAX_COUNT inclusive, then wraps to 0. It emits a one-cycle overflow pulse on each wrap.
- Generic leaf utility used by timers, tick generators and bring-up ("hello world") benches in the SoC.

Parameters:
- WIDTH, 8, bit width of count_o.
- MAX_COUNT, 255, terminal count value. The counter wraps to 0 on the enabled cycle after reaching this value.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- en_i  input  1  count enable; sampled on the rising clock edge.
- clear_i  input  1  synchronous clear; sampled on the rising clock edge.
- count_o  output  WIDTH  current count, registered.
- overflow_o  output  1  wrap pulse, registered.

Behaviour:
- One clock (clk_i). Reset rst_i is asynchronous and active-high.
- Reset:
  - Asserting rst_i immediately forces count_o=0 and overflow_o=0, without waiting for a clock edge.
  - Both outputs hold 0 while rst_i is high.
  - The first update after deassertion occurs at the next rising edge.
- Each rising edge (rst_i low), in priority order:
  1. clear_i=1: count_o <= 0, overflow_o <= 0. en_i is ignored on that edge.
  2. en_i=1 and count_o==MAX_COUNT: count_o <= 0, overflow_o <= 1.
  3. en_i=1 otherwise: count_o <= count_o+1, overflow_o <= 0.
  4. en_i=0: count_o holds, overflow_o <= 0.
- Latency: count_o reflects an enable sampled at edge N immediately after edge N (one-cycle register latency). There is no combinational path from inputs to outputs.
- overflow_o:
  - High for exactly one cycle, coincident with the first cycle in which count_o==0 after a wrap.
  - Continuous enable gives one pulse every MAX_COUNT+1 cycles.
- Sequence: MAX_COUNT+1 consecutive enabled edges from 0 return count_o to 0 with overflow_o=1.
- Simultaneous events:
  - clear_i with en_i at terminal count: clear wins, and no overflow pulse is generated.
  - rst_i overrides everything, asynchronously.
- Mid-operation reset: outputs drop to 0 without waiting for a clock edge. No pending state survives.
- Width rules:
  - Elaboration fails (static assertion) unless WIDTH >= 1, MAX_COUNT >= 1 and MAX_COUNT <= 2**WIDTH-1.
  - The increment is computed in WIDTH bits. The compare against MAX_COUNT uses MAX_COUNT truncated to WIDTH via an explicit cast.
  - If count_o is ever above MAX_COUNT (unreachable by design), an enabled edge wraps it to 0 the same way as the terminal count.
- Simulation-only assertions, disabled during reset:
  - count_o never exceeds MAX_COUNT.
  - overflow_o implies count_o==0.
  - overflow_o is never high for two consecutive cycles when MAX_COUNT >= 1.

Decomposition:
- No shared package needed. The parameters are local to the block and there are no shared typedefs.
- Single flat module with no sub-modules.
- Next-state logic in one combinational block; the count and overflow registers in one asynchronous-reset sequential block; parameter checks and assertions in a separate section.

Test Plan (WIDTH=8, MAX_COUNT=10, 10 ns clock):
- Reset held 5 cycles, then released with en_i=0 for 10 cycles -> count_o=0 and overflow_o=0 throughout.
- en_i=1 for 5 edges from 0 -> count_o=5, overflow_o=0.
- Continue en_i=1 for 6 more edges -> count_o sequence 6,7,8,9,10,0. overflow_o=1 only in the cycle where count_o=0, then 0 on the next edge with count_o=1.
- With count_o nonzero and en_i=1: clear_i=1 for one edge -> count_o=0. Next edge with clear_i=0, en_i=1 -> count_o=1.
- Drive count_o to 10, then assert clear_i and en_i on the same edge -> count_o=0, overflow_o=0 (clear priority, no pulse).
- Assert rst_i mid-count (count_o=7) between clock edges -> count_o=0 and overflow_o=0 before the next rising edge. Release rst_i with en_i=1 -> count_o=1 after the first edge.
